// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//
// Register file with two write ports (primary ALU/LW writeback and multdiv
// writeback), two combinational read ports, optional same-cycle write-to-read
// bypass, and a per-register pending scoreboard.
//
// The scoreboard lets decode stall on operands whose value is still being
// computed by the multi-cycle multdiv unit.
//
// Parameters
//   WIDTH       data width of every register and data port
//   ADDR_BITS   register address width, DEPTH = 2**ADDR_BITS
//   BYPASS      1: same-cycle write data is forwarded to the read ports
//               0: reads return array contents only
//   MAX_PENDING maximum number of simultaneously pending registers
//
// Ports
//   clock               system clock, rising edge
//   ctrl_reset          asynchronous active-low reset
//   ctrl_writeEnable    primary write enable
//   ctrl_writeReg       primary write address
//   data_writeReg       primary write data
//   ctrl_mdWriteEnable  multdiv writeback enable (clears pending bit)
//   ctrl_mdWriteReg     multdiv writeback address
//   data_mdWriteReg     multdiv writeback data
//   ctrl_mdIssue        multdiv op issued (marks destination pending)
//   ctrl_mdIssueReg     destination of the issued op
//   ctrl_readRegA/B     read addresses
//   data_readRegA/B     read data (combinational)
//   pending_readRegA/B  read register awaits a multdiv result
//   pending_full        pending count has reached MAX_PENDING
//   issue_accept        current ctrl_mdIssue is accepted (combinational)
//
// Issue handshake: ctrl_mdIssue is a request that takes effect on the rising
// edge only in a cycle where issue_accept is 1; a rejected request changes no
// state and the requester keeps it asserted until it is accepted.
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
  parameter int WIDTH       = 32,
  parameter int ADDR_BITS   = 5,
  parameter int BYPASS      = 1,
  parameter int MAX_PENDING = 4
) (
  input  logic                 clock,
  input  logic                 ctrl_reset,
  input  logic                 ctrl_writeEnable,
  input  logic [ADDR_BITS-1:0] ctrl_writeReg,
  input  logic [WIDTH-1:0]     data_writeReg,
  input  logic                 ctrl_mdWriteEnable,
  input  logic [ADDR_BITS-1:0] ctrl_mdWriteReg,
  input  logic [WIDTH-1:0]     data_mdWriteReg,
  input  logic                 ctrl_mdIssue,
  input  logic [ADDR_BITS-1:0] ctrl_mdIssueReg,
  input  logic [ADDR_BITS-1:0] ctrl_readRegA,
  input  logic [ADDR_BITS-1:0] ctrl_readRegB,
  output logic [WIDTH-1:0]     data_readRegA,
  output logic [WIDTH-1:0]     data_readRegB,
  output logic                 pending_readRegA,
  output logic                 pending_readRegB,
  output logic                 pending_full,
  output logic                 issue_accept
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int CW    = $clog2(MAX_PENDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PENDING);
  localparam logic BYP = (BYPASS != 0);
  localparam logic [ADDR_BITS-1:0] ZERO_ADDR = '0;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0] r_pending;
  logic [CW-1:0]    r_count;

  // ---------------------------------------------------------------------------
  // Write / issue qualification
  // ---------------------------------------------------------------------------
  logic w_pr_wr;        // primary write to a real register
  logic w_md_wr;        // multdiv write to a real register
  logic w_issue_nz;     // issue targets a real register
  logic w_issue_pend;   // issue target is already pending
  logic w_md_clears;    // multdiv write hits a pending register
  logic w_room;         // scoreboard has a free slot
  logic w_accept;
  logic w_new_set;      // accepted issue creates a new pending entry
  logic w_clear;        // multdiv write retires a pending entry
  logic w_same_reg;     // issue and multdiv write name the same register

  assign w_pr_wr      = ctrl_writeEnable   && (ctrl_writeReg   != ZERO_ADDR);
  assign w_md_wr      = ctrl_mdWriteEnable && (ctrl_mdWriteReg != ZERO_ADDR);
  assign w_issue_nz   = ctrl_mdIssueReg != ZERO_ADDR;
  assign w_issue_pend = r_pending[ctrl_mdIssueReg];
  assign w_md_clears  = w_md_wr && r_pending[ctrl_mdWriteReg];
  assign w_room       = r_count < MAX_CNT;
  assign w_same_reg   = ctrl_mdIssueReg == ctrl_mdWriteReg;

  // A multdiv write that retires an entry frees its slot in the same cycle,
  // so a full scoreboard can still take a new issue alongside it.
  assign w_accept = ctrl_reset && ctrl_mdIssue &&
                    (!w_issue_nz || w_issue_pend || w_room || w_md_clears);

  assign w_new_set = w_accept && w_issue_nz && !w_issue_pend;

  // When issue and writeback hit the same register, the set wins, so the
  // writeback does not retire the entry.
  assign w_clear = w_md_clears && !(w_accept && w_same_reg);

  assign issue_accept = w_accept;
  assign pending_full = ctrl_reset && (r_count == MAX_CNT);

  // ---------------------------------------------------------------------------
  // Next-state of the pending vector
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0] w_pending_next;

  always_comb begin
    w_pending_next = r_pending;
    if (w_md_wr) begin
      w_pending_next[ctrl_mdWriteReg] = 1'b0;
    end
    // Applied after the clear so a same-register issue keeps the bit set.
    if (w_accept && w_issue_nz) begin
      w_pending_next[ctrl_mdIssueReg] = 1'b1;
    end
    w_pending_next[0] = 1'b0;
  end

  logic [CW-1:0] w_count_next;

  always_comb begin
    w_count_next = r_count;
    case ({w_new_set, w_clear})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_pending <= '0;
      r_count   <= '0;
    end else begin
      if (w_pr_wr) begin
        r_regs[ctrl_writeReg] <= data_writeReg;
      end
      // Later assignment wins: multdiv has priority on a same-register write.
      if (w_md_wr) begin
        r_regs[ctrl_mdWriteReg] <= data_mdWriteReg;
      end
      r_pending <= w_pending_next;
      r_count   <= w_count_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  function automatic logic [WIDTH-1:0] read_value(
    input logic [ADDR_BITS-1:0] addr
  );
    logic [WIDTH-1:0] v;
    v = r_regs[addr];
    if (BYP) begin
      if (w_md_wr && (ctrl_mdWriteReg == addr)) begin
        v = data_mdWriteReg;
      end else if (w_pr_wr && (ctrl_writeReg == addr)) begin
        v = data_writeReg;
      end
    end
    if (addr == ZERO_ADDR) begin
      v = '0;
    end
    return v;
  endfunction

  // With bypass, a multdiv result arriving this cycle is already on the read
  // port, so the operand is no longer stalled unless it is re-issued now.
  function automatic logic read_pending(
    input logic [ADDR_BITS-1:0] addr
  );
    logic p;
    p = r_pending[addr] && (addr != ZERO_ADDR);
    if (BYP && w_md_wr && (ctrl_mdWriteReg == addr) &&
        !(w_accept && (ctrl_mdIssueReg == addr))) begin
      p = 1'b0;
    end
    return p;
  endfunction

  always_comb begin
    data_readRegA    = '0;
    data_readRegB    = '0;
    pending_readRegA = 1'b0;
    pending_readRegB = 1'b0;
    if (ctrl_reset) begin
      data_readRegA    = read_value(ctrl_readRegA);
      data_readRegB    = read_value(ctrl_readRegB);
      pending_readRegA = read_pending(ctrl_readRegA);
      pending_readRegB = read_pending(ctrl_readRegB);
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_regfile_scoreboard
//
// Drives two instances side by side (BYPASS=1 and BYPASS=0) from the same
// inputs and compares both against a behavioural model: an array of register
// values plus a set of pending registers whose size is the pending count.
// -----------------------------------------------------------------------------
module tb_regfile_scoreboard;

  localparam int W   = 32;
  localparam int AB  = 5;
  localparam int N   = 32;
  localparam int MAXP = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Stimulus signals
  // ---------------------------------------------------------------------------
  logic          we, mdwe, iss;
  logic [AB-1:0] wr, mdr, isr, ra, rb;
  logic [W-1:0]  wd, mdd;

  logic [W-1:0] rda_1, rdb_1, rda_0, rdb_0;
  logic         pa_1, pb_1, pa_0, pb_0, full_1, full_0, acc_1, acc_0;

  regfile_scoreboard #(.WIDTH(W), .ADDR_BITS(AB), .BYPASS(1), .MAX_PENDING(MAXP)) u_dut_byp (
    .clock(clock), .ctrl_reset(rst_n),
    .ctrl_writeEnable(we), .ctrl_writeReg(wr), .data_writeReg(wd),
    .ctrl_mdWriteEnable(mdwe), .ctrl_mdWriteReg(mdr), .data_mdWriteReg(mdd),
    .ctrl_mdIssue(iss), .ctrl_mdIssueReg(isr),
    .ctrl_readRegA(ra), .ctrl_readRegB(rb),
    .data_readRegA(rda_1), .data_readRegB(rdb_1),
    .pending_readRegA(pa_1), .pending_readRegB(pb_1),
    .pending_full(full_1), .issue_accept(acc_1)
  );

  regfile_scoreboard #(.WIDTH(W), .ADDR_BITS(AB), .BYPASS(0), .MAX_PENDING(MAXP)) u_dut_nobyp (
    .clock(clock), .ctrl_reset(rst_n),
    .ctrl_writeEnable(we), .ctrl_writeReg(wr), .data_writeReg(wd),
    .ctrl_mdWriteEnable(mdwe), .ctrl_mdWriteReg(mdr), .data_mdWriteReg(mdd),
    .ctrl_mdIssue(iss), .ctrl_mdIssueReg(isr),
    .ctrl_readRegA(ra), .ctrl_readRegB(rb),
    .data_readRegA(rda_0), .data_readRegB(rdb_0),
    .pending_readRegA(pa_0), .pending_readRegB(pb_0),
    .pending_full(full_0), .issue_accept(acc_0)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [W-1:0] m_regs [N];
  bit           m_pend [N];
  bit           m_acc;

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  function automatic int pend_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += m_pend[i] ? 1 : 0;
    return c;
  endfunction

  function automatic bit exp_accept();
    if (!rst_n || !iss) return 1'b0;
    if (isr == 0 || m_pend[isr]) return 1'b1;
    if (pend_count() < MAXP) return 1'b1;
    return mdwe && (mdr != 0) && m_pend[mdr];
  endfunction

  function automatic logic [W-1:0] exp_read(input bit byp, input logic [AB-1:0] a);
    if (!rst_n || a == 0) return '0;
    if (byp && mdwe && mdr == a) return mdd;
    if (byp && we && wr == a) return wd;
    return m_regs[a];
  endfunction

  function automatic logic [W-1:0] exp_pend(input bit byp, input logic [AB-1:0] a, input bit acc);
    if (!rst_n || a == 0 || !m_pend[a]) return '0;
    if (byp && mdwe && mdr == a && !(acc && isr == a)) return '0;
    return 32'd1;
  endfunction

  task automatic clear_inputs();
    we = 0; mdwe = 0; iss = 0;
    wr = '0; mdr = '0; isr = '0; ra = '0; rb = '0;
    wd = '0; mdd = '0;
  endtask

  // Compare every output of both instances against the model.
  task automatic check_outputs();
    logic [W-1:0] full_e;
    #1;
    if (!rst_n) model_clear();
    m_acc  = exp_accept();
    full_e = (rst_n && pend_count() == MAXP) ? 32'd1 : 32'd0;
    check_val("rdA_byp",   rda_1, exp_read(1'b1, ra));
    check_val("rdB_byp",   rdb_1, exp_read(1'b1, rb));
    check_val("rdA_nobyp", rda_0, exp_read(1'b0, ra));
    check_val("rdB_nobyp", rdb_0, exp_read(1'b0, rb));
    check_val("pA_byp",    {31'd0, pa_1}, exp_pend(1'b1, ra, m_acc));
    check_val("pB_byp",    {31'd0, pb_1}, exp_pend(1'b1, rb, m_acc));
    check_val("pA_nobyp",  {31'd0, pa_0}, exp_pend(1'b0, ra, m_acc));
    check_val("pB_nobyp",  {31'd0, pb_0}, exp_pend(1'b0, rb, m_acc));
    check_val("full_byp",  {31'd0, full_1}, full_e);
    check_val("full_nobyp",{31'd0, full_0}, full_e);
    check_val("acc_byp",   {31'd0, acc_1}, {31'd0, m_acc});
    check_val("acc_nobyp", {31'd0, acc_0}, {31'd0, m_acc});
  endtask

  // Advance one clock: apply the model update at the edge, then release inputs.
  task automatic tick();
    @(posedge clock);
    if (rst_n) begin
      if (we && wr != 0) m_regs[wr] = wd;
      if (mdwe && mdr != 0) m_regs[mdr] = mdd;
      if (mdwe && mdr != 0) m_pend[mdr] = 1'b0;
      if (m_acc && isr != 0) m_pend[isr] = 1'b1;
    end else begin
      model_clear();
    end
    @(negedge clock);
    clear_inputs();
  endtask

  task automatic step();
    check_outputs();
    tick();
  endtask

  task automatic do_issue(input logic [AB-1:0] r);
    iss = 1; isr = r;
    step();
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    clear_inputs();
    model_clear();
    m_acc = 0;
    @(negedge clock);

    // Reset: everything reads zero even with a write and issue presented.
    we = 1; wr = 5'd5; wd = 32'hAAAA_5555; iss = 1; isr = 5'd3; ra = 5'd5;
    check_outputs();
    check_val("rst_rdA", rda_1, 32'd0);
    check_val("rst_acc", {31'd0, acc_1}, 32'd0);
    tick();
    rst_n = 1;

    // r5 = DEADBEEF, visible next cycle on both variants.
    we = 1; wr = 5'd5; wd = 32'hDEAD_BEEF;
    step();
    ra = 5'd5;
    check_outputs();
    check_val("r5_byp",   rda_1, 32'hDEAD_BEEF);
    check_val("r5_nobyp", rda_0, 32'hDEAD_BEEF);
    tick();

    // Writes to r0 are discarded.
    we = 1; wr = 5'd0; wd = 32'h1;
    step();
    ra = 5'd0;
    check_outputs();
    check_val("r0_zero", rda_1, 32'd0);
    tick();

    // Same-cycle bypass vs. next-cycle visibility.
    we = 1; wr = 5'd7; wd = 32'h1234_5678; ra = 5'd7;
    check_outputs();
    check_val("byp_same", rda_1, 32'h1234_5678);
    check_val("nobyp_old", rda_0, 32'd0);
    tick();
    ra = 5'd7;
    check_outputs();
    check_val("nobyp_next", rda_0, 32'h1234_5678);
    tick();

    // Both ports write r9: multdiv wins.
    we = 1; wr = 5'd9; wd = 32'h1; mdwe = 1; mdr = 5'd9; mdd = 32'h2;
    step();
    ra = 5'd9;
    check_outputs();
    check_val("r9_md_wins", rda_0, 32'h2);
    tick();

    // Issue r3, then retire it.
    do_issue(5'd3);
    rb = 5'd3;
    check_outputs();
    check_val("r3_pend", {31'd0, pb_0}, 32'd1);
    tick();
    mdwe = 1; mdr = 5'd3; mdd = 32'h55;
    step();
    rb = 5'd3;
    check_outputs();
    check_val("r3_clear", {31'd0, pb_0}, 32'd0);
    check_val("r3_val", rdb_0, 32'h55);
    tick();

    // Fill the scoreboard.
    for (int r = 1; r <= 4; r++) do_issue(AB'(r));
    iss = 1; isr = 5'd6; ra = 5'd6;
    check_outputs();
    check_val("full_set", {31'd0, full_1}, 32'd1);
    check_val("r6_reject", {31'd0, acc_1}, 32'd0);
    tick();
    ra = 5'd6;
    check_outputs();
    check_val("r6_not_pend", {31'd0, pa_1}, 32'd0);
    tick();
    iss = 1; isr = 5'd2;
    check_outputs();
    check_val("r2_reissue", {31'd0, acc_1}, 32'd1);
    tick();
    iss = 1; isr = 5'd6; mdwe = 1; mdr = 5'd1; mdd = 32'h11;
    check_outputs();
    check_val("r6_swap", {31'd0, acc_1}, 32'd1);
    tick();
    check_outputs();
    check_val("still_full", {31'd0, full_0}, 32'd1);
    tick();

    // Retire r2, make r8 pending, then issue + writeback r8 together.
    mdwe = 1; mdr = 5'd2; mdd = 32'h22;
    step();
    do_issue(5'd8);
    iss = 1; isr = 5'd8; mdwe = 1; mdr = 5'd8; mdd = 32'h88; ra = 5'd8;
    check_outputs();
    check_val("r8_pend_byp", {31'd0, pa_1}, 32'd1);
    tick();
    ra = 5'd8;
    check_outputs();
    check_val("r8_val", rda_0, 32'h88);
    check_val("r8_pend", {31'd0, pa_0}, 32'd1);
    tick();

    // Primary write to pending r4 keeps it pending; then reset mid-cycle.
    we = 1; wr = 5'd4; wd = 32'hFF;
    step();
    ra = 5'd4; rb = 5'd8;
    check_outputs();
    check_val("r4_ff", rda_0, 32'hFF);
    check_val("r4_pend", {31'd0, pa_0}, 32'd1);
    #2 rst_n = 0;
    check_outputs();
    check_val("midrst_rd", rda_0, 32'd0);
    check_val("midrst_pend", {31'd0, pa_0}, 32'd0);
    check_val("midrst_full", {31'd0, full_0}, 32'd0);
    tick();
    rst_n = 1;
    iss = 1; isr = 5'd1;
    check_outputs();
    check_val("post_rst_acc", {31'd0, acc_1}, 32'd1);
    tick();

    // Randomized traffic over a small register window to force collisions.
    for (int c = 0; c < 600; c++) begin
      we   = ($urandom_range(0, 2) == 0);
      wr   = AB'($urandom_range(0, 11));
      wd   = $urandom;
      mdwe = ($urandom_range(0, 2) == 0);
      mdr  = AB'($urandom_range(0, 11));
      mdd  = $urandom;
      iss  = ($urandom_range(0, 1) == 0);
      isr  = AB'($urandom_range(0, 11));
      ra   = AB'($urandom_range(0, 11));
      rb   = AB'($urandom_range(0, 11));
      if ($urandom_range(0, 199) == 0) begin
        #3 rst_n = 0;
        check_outputs();
        tick();
        rst_n = 1;
      end else begin
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
